// File: rtl/alu_result_stage_pkg.sv
// Shared widths, NZCV bit positions and the buffered entry type for the ALU result stage.
package alu_result_stage_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned FLAG_W_DEF = 4;
    localparam int unsigned RD_W_DEF   = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] result;
        logic [RD_W_DEF-1:0]   rd;
    } entry_t;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready buffer; output is always taken from the head register.
module alu_skid_buf
    import alu_result_stage_pkg::*;
#(
    parameter type data_t = entry_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  flush_i,
    input  logic  in_valid_i,
    output logic  in_ready_o,
    input  data_t in_data_i,
    output logic  out_valid_o,
    input  logic  out_ready_i,
    output data_t out_data_o
);

    logic [1:0] count_q, count_d;
    data_t      head_q, head_d;
    data_t      tail_q, tail_d;
    logic       push, pop;

    // Ready comes only from occupancy so it never depends on out_ready_i.
    assign in_ready_o  = (count_q < 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = in_data_i;
                    end else begin
                        tail_d = in_data_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                // Push and pop together only happen at occupancy 1.
                2'b11: head_d = in_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: skid-buffers results towards write-back and owns the NZCV flag register.
// Define FLAG_FORWARD_EN to bypass a same-cycle flag update onto the Flag output.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned FLAG_W = FLAG_W_DEF,
    parameter int unsigned RD_W   = RD_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_Result,
    input  logic [RD_W-1:0]   In_Rd,
    input  logic [FLAG_W-1:0] In_New_Flag,
    input  logic              In_S,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Result,
    output logic [RD_W-1:0]   Out_Rd,
    output logic [FLAG_W-1:0] Flag
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [RD_W-1:0]   rd;
    } stage_entry_t;

    stage_entry_t      in_entry, out_entry;
    logic              accept;
    logic [FLAG_W-1:0] flag_q, flag_d;

    assign in_entry = '{result: In_Result, rd: In_Rd};

    alu_skid_buf #(
        .data_t (stage_entry_t)
    ) u_skid_buf (
        .clk_i       (Clk),
        .rst_ni      (Rst_n),
        .flush_i     (Flush),
        .in_valid_i  (In_Valid),
        .in_ready_o  (In_Ready),
        .in_data_i   (in_entry),
        .out_valid_o (Out_Valid),
        .out_ready_i (Out_Ready),
        .out_data_o  (out_entry)
    );

    assign Out_Result = out_entry.result;
    assign Out_Rd     = out_entry.rd;

    // A flushed accept still commits its flags; flush only drops buffered data.
    assign accept = In_Valid && In_Ready;

    always_comb begin
        flag_d = flag_q;
        if (accept && In_S) begin
            flag_d = In_New_Flag;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

`ifdef FLAG_FORWARD_EN
    assign Flag = (accept && In_S) ? In_New_Flag : flag_q;
`else
    assign Flag = flag_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus a random run against a queue model.
module tb_alu_result_stage;

    logic        Clk = 1'b0;
    logic        Rst_n, Flush, In_Valid, In_Ready, In_S, Out_Valid, Out_Ready;
    logic [31:0] In_Result, Out_Result;
    logic [3:0]  In_Rd, Out_Rd, In_New_Flag, Flag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  rd;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] out_log[$];
    logic [3:0]  mflag;
    bit          last_acc;

    alu_result_stage dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Flush       (Flush),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .In_Result   (In_Result),
        .In_Rd       (In_Rd),
        .In_New_Flag (In_New_Flag),
        .In_S        (In_S),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Out_Result  (Out_Result),
        .Out_Rd      (Out_Rd),
        .Flag        (Flag)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

`ifdef FLAG_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Advance one clock edge and apply the architectural rules to the model.
    task automatic step();
        bit acc, emt;
        @(posedge Clk);
        acc = In_Valid && (mq.size() < 2);
        emt = (mq.size() > 0) && Out_Ready;
        last_acc = acc;
        if (!Rst_n) begin
            mq.delete();
            mflag = 4'b0000;
            last_acc = 1'b0;
        end else begin
            if (acc && In_S) mflag = In_New_Flag;
            if (Flush) begin
                mq.delete();
            end else begin
                if (emt) begin
                    out_log.push_back(mq[0].res);
                    void'(mq.pop_front());
                end
                if (acc) mq.push_back('{res: In_Result, rd: In_Rd});
            end
        end
        #1;
    endtask

    function automatic logic [3:0] exp_flag();
        if (FWD && In_Valid && In_S && (mq.size() < 2)) return In_New_Flag;
        return mflag;
    endfunction

    task automatic drive(input logic [31:0] res, input logic [3:0] rd,
                         input logic [3:0] nf, input logic s);
        In_Valid    = 1'b1;
        In_Result   = res;
        In_Rd       = rd;
        In_New_Flag = nf;
        In_S        = s;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        step();
        step();
        Rst_n = 1'b1;
        #1;
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", Out_Valid); end
        total++; if (Flag !== 4'b0000) begin bad++; $display("FAIL reset_flag got=%b exp=0000", Flag); end
        total++; if (In_Ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", In_Ready); end
        total++; if (Out_Result !== 32'h0) begin bad++; $display("FAIL reset_out_result got=%h exp=0", Out_Result); end
        total++; if (Out_Rd !== 4'h0) begin bad++; $display("FAIL reset_out_rd got=%h exp=0", Out_Rd); end
    endtask

    task automatic test_single();
        Out_Ready = 1'b1;
        drive(32'h4000_0000, 4'd3, 4'b0000, 1'b0);
        step();
        In_Valid = 1'b0;
        #1;
        total++; if (Out_Valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", Out_Valid); end
        total++; if (Out_Result !== 32'h4000_0000) begin bad++; $display("FAIL single_result got=%h exp=40000000", Out_Result); end
        total++; if (Out_Rd !== 4'd3) begin bad++; $display("FAIL single_rd got=%0d exp=3", Out_Rd); end
        total++; if (Flag !== 4'b0000) begin bad++; $display("FAIL single_flag got=%b exp=0000", Flag); end
        step();
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", Out_Valid); end
    endtask

    task automatic test_flags();
        logic [3:0] pre;
        pre = FWD ? 4'b1010 : 4'b0000;
        Out_Ready = 1'b1;
        drive(32'hFFFF_FFFF, 4'd5, 4'b1010, 1'b1);
        #1;
        total++; if (Flag !== pre) begin bad++; $display("FAIL flag_same_cycle got=%b exp=%b", Flag, pre); end
        step();
        drive(32'h1, 4'd6, 4'b0100, 1'b0);
        #1;
        total++; if (Flag !== 4'b1010) begin bad++; $display("FAIL flag_after_set got=%b exp=1010", Flag); end
        step();
        In_Valid = 1'b0;
        #1;
        total++; if (Flag !== 4'b1010) begin bad++; $display("FAIL flag_s0_keep got=%b exp=1010", Flag); end
        total++; if (Out_Result !== 32'h1) begin bad++; $display("FAIL flag_second_result got=%h exp=1", Out_Result); end
        step();
    endtask

    task automatic test_backpressure();
        bit pend;
        Out_Ready = 1'b0;
        drive(32'd1, 4'd1, 4'b0000, 1'b0);
        step();
        drive(32'd2, 4'd2, 4'b0000, 1'b0);
        step();
        drive(32'd3, 4'd3, 4'b0000, 1'b0);
        #1;
        total++; if (In_Ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", In_Ready); end
        step();
        total++; if (Out_Valid !== 1'b1 || Out_Result !== 32'd1) begin
            bad++; $display("FAIL bp_hold got=%b/%h exp=1/1", Out_Valid, Out_Result);
        end
        total++; if (In_Ready !== 1'b0) begin bad++; $display("FAIL bp_still_full got=%b exp=0", In_Ready); end
        out_log.delete();
        Out_Ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pend = In_Valid && (mq.size() < 2);
            step();
            if (pend) In_Valid = 1'b0;
            if (mq.size() == 0 && !In_Valid) break;
        end
        total++; if (out_log.size() != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", out_log.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < out_log.size()) begin
                total++; if (out_log[k] !== 32'(k + 1)) begin
                    bad++; $display("FAIL bp_order[%0d] got=%0d exp=%0d", k, out_log[k], k + 1);
                end
            end
        end
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", Out_Valid); end
    endtask

    task automatic test_back_to_back();
        Out_Ready = 1'b1;
        out_log.delete();
        for (int k = 10; k <= 12; k++) begin
            drive(32'(k), 4'(k), 4'b0000, 1'b0);
            step();
            total++; if (Out_Valid !== 1'b1 || Out_Result !== 32'(k)) begin
                bad++; $display("FAIL b2b_out[%0d] got=%b/%0d exp=1/%0d", k, Out_Valid, Out_Result, k);
            end
            total++; if (In_Ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", k, In_Ready); end
        end
        In_Valid = 1'b0;
        step();
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", Out_Valid); end
        total++; if (out_log.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", out_log.size()); end
    endtask

    task automatic test_flush();
        Out_Ready = 1'b0;
        out_log.delete();
        drive(32'h20, 4'd1, 4'b0000, 1'b0);
        step();
        drive(32'h21, 4'd2, 4'b0000, 1'b0);
        step();
        // Full: the flagged op is not accepted, so flags must not move.
        drive(32'h22, 4'd3, 4'b0100, 1'b1);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        In_Valid = 1'b0;
        #1;
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL flush_full_valid got=%b exp=0", Out_Valid); end
        total++; if (In_Ready !== 1'b1) begin bad++; $display("FAIL flush_full_ready got=%b exp=1", In_Ready); end
        total++; if (Flag !== 4'b1010) begin bad++; $display("FAIL flush_full_flag got=%b exp=1010", Flag); end
        drive(32'h30, 4'd4, 4'b0000, 1'b0);
        step();
        drive(32'h31, 4'd5, 4'b0100, 1'b1);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        In_Valid = 1'b0;
        #1;
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL flush_acc_valid got=%b exp=0", Out_Valid); end
        total++; if (Flag !== 4'b0100) begin bad++; $display("FAIL flush_acc_flag got=%b exp=0100", Flag); end
        Out_Ready = 1'b1;
        step();
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL flush_no_emit got=%b exp=0", Out_Valid); end
        total++; if (out_log.size() != 0) begin bad++; $display("FAIL flush_log got=%0d exp=0", out_log.size()); end
    endtask

    task automatic test_reset_mid();
        Out_Ready = 1'b0;
        drive(32'h40, 4'd7, 4'b0011, 1'b1);
        step();
        drive(32'h41, 4'd8, 4'b0000, 1'b0);
        step();
        In_Valid = 1'b0;
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        #1;
        total++; if (Out_Valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", Out_Valid); end
        total++; if (Flag !== 4'b0000) begin bad++; $display("FAIL rmid_flag got=%b exp=0000", Flag); end
        total++; if (In_Ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", In_Ready); end
        total++; if (Out_Result !== 32'h0) begin bad++; $display("FAIL rmid_result got=%h exp=0", Out_Result); end
    endtask

    task automatic test_random();
        logic [3:0] ef;
        last_acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!(In_Valid && !last_acc)) begin
                In_Valid    = ($urandom_range(0, 3) != 0);
                In_Result   = $urandom;
                In_Rd       = 4'($urandom);
                In_New_Flag = 4'($urandom);
                In_S        = $urandom_range(0, 1) == 1;
            end
            Flush     = ($urandom_range(0, 15) == 0);
            Out_Ready = Flush ? 1'b0 : ($urandom_range(0, 2) != 0);
            #1;
            ef = exp_flag();
            total++; if (Flag !== ef) begin bad++; $display("FAIL rnd_flag[%0d] got=%b exp=%b", c, Flag, ef); end
            total++; if (In_Ready !== (mq.size() < 2)) begin
                bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, In_Ready, mq.size() < 2);
            end
            total++; if (Out_Valid !== (mq.size() > 0)) begin
                bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, Out_Valid, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                total++; if (Out_Result !== mq[0].res || Out_Rd !== mq[0].rd) begin
                    bad++; $display("FAIL rnd_head[%0d] got=%h/%0d exp=%h/%0d",
                                    c, Out_Result, Out_Rd, mq[0].res, mq[0].rd);
                end
            end
            step();
        end
        Flush    = 1'b0;
        In_Valid = 1'b0;
    endtask

    initial begin
        Rst_n       = 1'b0;
        Flush       = 1'b0;
        In_Valid    = 1'b0;
        In_Result   = '0;
        In_Rd       = '0;
        In_New_Flag = '0;
        In_S        = 1'b0;
        Out_Ready   = 1'b0;
        mflag       = 4'b0000;
        last_acc    = 1'b0;
        test_reset();
        test_single();
        test_flags();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
